ibus_line_responder: RTL and testbench
======================================

// Module: ibus_line_responder
// PURPOSE
//  Responder end of the instruction bus: accepts ibus_req_t from the fetch stage and returns ibus_resp_t.
//  Holds one LINE_WORDS-word line buffer. Hits answer in 1 cycle; misses refill the line by burst from backing memory.
//  Sits between fetch and the memory arbiter; flush hook is provided for fence.i.
// PARAMETERS
//  LINE_WORDS   8             32-bit words per line; power of two, 2..16
//  ADDR_W       64            width of addr_t / mem_req_addr
// PORTS
//  clk             in   1        clock; all state updates on posedge
//  rst_n           in   1        asynchronous, active-low reset
//  ireq            in   ibus_req_t   .valid, .addr from fetch; held stable until answered
//  iresp           out  ibus_resp_t  .addr_ok, .data_ok, .data(32) to fetch
//  flush           in   1        invalidate line buffer (fence.i)
//  mem_req_valid   out  1        burst read request
//  mem_req_ready   in   1        memory accepts request
//  mem_req_addr    out  ADDR_W   line-aligned base address
//  mem_req_len     out  5        beats-1 (= LINE_WORDS-1)
//  mem_resp_valid  in   1        one 32-bit beat valid
//  mem_resp_data   in   32       beat data, ascending word order
//  mem_resp_last   in   1        final beat marker (checked only)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; line_valid=0; beat count=0.
//   iresp.addr_ok=data_ok=0, iresp.data=0; mem_req_valid=0, mem_req_addr=0.
//  Handshake: a request is accepted in IDLE when ireq.valid=1, and its addr is captured (req_addr).
//   The response drives addr_ok=data_ok=1 together for exactly one cycle, with data valid.
//   Both flags are 0 in every other cycle. ireq.valid in the RESP cycle and in non-IDLE states is ignored.
//   The next acceptance is possible in the cycle after RESP.
//  Index: word = req_addr[2+:log2(LINE_WORDS)].
//   tag = req_addr[ADDR_W-1 : 2+log2(LINE_WORDS)].
//  FSM:
//   IDLE   -> RESP    when valid and (req_addr[1:0]!=0 or (line_valid and tag==line_tag))
//   IDLE   -> MREQ    when valid and miss
//   MREQ   -> MDATA   when mem_req_ready. mem_req_valid=1 and addr stable throughout MREQ.
//                     mem_req_addr = {tag, zeros}.
//   MDATA  -> RESP    after LINE_WORDS beats. Each mem_resp_valid writes buf[cnt] and increments cnt.
//                     On the final beat, line_tag<=tag and line_valid<=1 (unless killed).
//   RESP   -> IDLE    unconditionally.
//  Latency: hit = 1 cycle after acceptance. Miss = 2 + memory grant wait + LINE_WORDS beats.
//  Misaligned (addr[1:0]!=0): data=32'h0, no memory access, line state untouched. Fetch raises the trap.
//  Beat counter is log2(LINE_WORDS)+1 bits and never wraps. Beats outside MDATA are ignored.
//   mem_resp_last must coincide with the final beat; a mismatch fires an assertion (sim only), and count governs.
//  flush:
//   - in IDLE/RESP: line_valid<=0 next cycle.
//   - in MREQ/MDATA: sets kill. The refill completes and returns correct data, but line_valid stays 0.
//   - Simultaneous with acceptance: the request is treated as a miss.
//  Mid-operation reset: the burst is abandoned and mem_req_valid drops immediately.
//   The memory side must tolerate this as an aborted burst.
// STRUCTURE
//  common package additions: ibus_rsp_state_t enum {IDLE,MREQ,MDATA,RESP}; LINE_WORDS default constant.
//  Sub-module ibus_line_buf: LINE_WORDS x 32 register array, 1 write port (idx, data, we) and 1 async read port.
//   It has no reset; contents are qualified by line_valid.
//  Top module contains the FSM, tag/valid registers, beat counter and kill flag.
// TESTING
//  1. Cold miss: ireq addr=0x8000_0004, memory returns 0x1000+i for i=0..7.
//     -> 1 request at 0x8000_0000, len=7; resp data=0x1001 one cycle; line_valid=1.
//  2. Hit after (1): addr=0x8000_001C -> resp next cycle, data=0x1007, no mem_req_valid.
//  3. Tag mismatch: addr=0x8000_0020 -> new burst at 0x8000_0020; old line replaced.
//     A re-request of 0x8000_0004 then misses again.
//  4. flush asserted during beat 3 of a refill -> response still correct, line_valid=0.
//     The same address re-requested refills.
//  5. Misaligned addr=0x8000_0002 -> resp next cycle, data=0, no memory traffic.
//  6. rst_n low during MDATA beat 5 -> all outputs 0 asynchronously.
//     After release, the request to the same addr performs a full 8-beat refill.

Source files
------------

// File: rtl/ibus_line_responder_pkg.sv
// Shared types for the instruction-bus line responder: request/response
// structs, responder FSM states and default geometry.
package ibus_line_responder_pkg;

   localparam int DEFAULT_LINE_WORDS = 8;
   localparam int DEFAULT_ADDR_W     = 64;
   localparam int MEM_LEN_W          = 5;

   typedef logic [DEFAULT_ADDR_W-1:0] addr_t;

   typedef struct packed {
      logic  valid;
      addr_t addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef enum logic [1:0] {
      IDLE,
      MREQ,
      MDATA,
      RESP
   } ibus_rsp_state_t;

   // Burst length field encodes beats-1.
   function automatic logic [MEM_LEN_W-1:0] burst_len(input int words);
      return MEM_LEN_W'(words - 1);
   endfunction

endpackage

// File: rtl/ibus_line_buf.sv
// One-line data store: LINE_WORDS x 32 registers, one write port and one
// asynchronous read port. No reset; contents are qualified by the owner's valid bit.
module ibus_line_buf #(
   parameter int LINE_WORDS = 8,
   parameter int IDX_W      = $clog2(LINE_WORDS)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  logic [31:0]      wdata,
   input  logic [IDX_W-1:0] ridx,
   output logic [31:0]      rdata
);

   logic [31:0] words [LINE_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         words[widx] <= wdata;
      end
   end

   assign rdata = words[ridx];

endmodule

// File: rtl/ibus_line_responder.sv
// Instruction-bus responder with a single-line buffer: hits answer the cycle
// after acceptance, misses refill the whole line with one burst read.
module ibus_line_responder
   import ibus_line_responder_pkg::*;
#(
   parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
   parameter int ADDR_W     = DEFAULT_ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  ibus_req_t            ireq,
   output ibus_resp_t           iresp,
   input  logic                 flush,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic [ADDR_W-1:0]    mem_req_addr,
   output logic [MEM_LEN_W-1:0] mem_req_len,
   input  logic                 mem_resp_valid,
   input  logic [31:0]          mem_resp_data,
   input  logic                 mem_resp_last
);

   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam int CNT_W = IDX_W + 1;
   localparam int TAG_W = ADDR_W - 2 - IDX_W;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

   ibus_rsp_state_t   state_reg;
   ibus_rsp_state_t   state_next;
   logic [ADDR_W-1:0] req_addr_reg;
   logic [TAG_W-1:0]  line_tag_reg;
   logic              line_valid_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              kill_reg;

   logic [ADDR_W-1:0] in_addr;
   logic [TAG_W-1:0]  in_tag;
   logic              in_misaligned;
   logic              in_hit;
   logic              accept;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_word;
   logic              req_misaligned;
   logic              beat_we;
   logic              final_beat;
   logic [31:0]       rd_data;

   assign in_addr        = ireq.addr[ADDR_W-1:0];
   assign in_tag         = in_addr[ADDR_W-1 -: TAG_W];
   assign in_misaligned  = |in_addr[1:0];
   // A flush in the acceptance cycle forces the request down the miss path.
   assign in_hit         = line_valid_reg && (in_tag == line_tag_reg) && !flush;
   assign accept         = (state_reg == IDLE) && ireq.valid;

   assign req_tag        = req_addr_reg[ADDR_W-1 -: TAG_W];
   assign req_word       = req_addr_reg[2 +: IDX_W];
   assign req_misaligned = |req_addr_reg[1:0];

   assign beat_we        = (state_reg == MDATA) && mem_resp_valid;
   assign final_beat     = beat_we && (cnt_reg == LAST_BEAT);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (ireq.valid) begin
               if (in_misaligned || in_hit) begin
                  state_next = RESP;
               end else begin
                  state_next = MREQ;
               end
            end
         end
         MREQ: begin
            if (mem_req_ready) begin
               state_next = MDATA;
            end
         end
         MDATA: begin
            if (final_beat) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         req_addr_reg   <= '0;
         line_tag_reg   <= '0;
         line_valid_reg <= 1'b0;
         cnt_reg        <= '0;
         kill_reg       <= 1'b0;
      end else begin
         state_reg <= state_next;

         if (accept) begin
            req_addr_reg <= in_addr;
         end

         // The buffer is overwritten during a refill, so the old line is dropped up front.
         if (flush && (state_reg == IDLE || state_reg == RESP)) begin
            line_valid_reg <= 1'b0;
         end else if (accept && state_next == MREQ) begin
            line_valid_reg <= 1'b0;
         end else if (final_beat) begin
            line_tag_reg   <= req_tag;
            line_valid_reg <= !(kill_reg || flush);
         end

         if (state_reg == IDLE) begin
            kill_reg <= 1'b0;
         end else if (flush && (state_reg == MREQ || state_reg == MDATA)) begin
            kill_reg <= 1'b1;
         end

         if (state_reg == IDLE) begin
            cnt_reg <= '0;
         end else if (beat_we) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   ibus_line_buf #(
      .LINE_WORDS (LINE_WORDS),
      .IDX_W      (IDX_W)
   ) u_line_buf (
      .clk   (clk),
      .we    (beat_we),
      .widx  (cnt_reg[IDX_W-1:0]),
      .wdata (mem_resp_data),
      .ridx  (req_word),
      .rdata (rd_data)
   );

   always_comb begin
      iresp         = '0;
      iresp.addr_ok = (state_reg == RESP);
      iresp.data_ok = (state_reg == RESP);
      if (state_reg == RESP && !req_misaligned) begin
         iresp.data = rd_data;
      end
   end

   assign mem_req_valid = (state_reg == MREQ);
   assign mem_req_addr  = {req_tag, {(IDX_W + 2){1'b0}}};
   assign mem_req_len   = burst_len(LINE_WORDS);

`ifndef SYNTHESIS
   // The beat count decides the end of the burst; the last marker is only cross-checked.
   last_marker_check: assert property (@(posedge clk) disable iff (!rst_n)
      beat_we |-> (mem_resp_last == (cnt_reg == LAST_BEAT)));
`endif

endmodule

// File: tb/tb_ibus_line_responder.sv
// Directed bench for ibus_line_responder: a cycle-level memory model serves
// bursts while each scenario task checks data, latency and memory traffic.
module tb_ibus_line_responder;
   import ibus_line_responder_pkg::*;

   localparam int LW = 8;

   logic        clk;
   logic        rst_n;
   ibus_req_t   ireq;
   ibus_resp_t  iresp;
   logic        flush;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic [4:0]  mem_req_len;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_last;

   int total_cnt;
   int passed_cnt;

   ibus_line_responder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ireq           (ireq),
      .iresp          (iresp),
      .flush          (flush),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_len    (mem_req_len),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_last  (mem_resp_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called right after a negedge; returns right after the negedge following the response.
   // flush_beat: -1 none, -2 with acceptance, n>=0 alongside burst beat n.
   task automatic run_txn(input logic [63:0] a, input logic [31:0] base, input int grant_wait,
                          input int flush_beat, output logic [31:0] data, output int lat,
                          output int nreq, output logic [63:0] raddr, output int ok_cycles,
                          output int flag_err);
      int  waitc;
      int  beat;
      bit  granted;
      bit  done;
      data = '0; lat = -1; nreq = 0; raddr = '0; ok_cycles = 0; flag_err = 0;
      waitc = 0; beat = 0; granted = 0; done = 0;
      ireq.valid = 1'b1;
      ireq.addr  = a;
      flush      = (flush_beat == -2);
      for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
         @(negedge clk);
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_last = 1'b0; flush = 1'b0;
         if (iresp.addr_ok !== iresp.data_ok) flag_err++;
         if (iresp.data_ok === 1'b1) begin
            ok_cycles++;
            if (lat < 0) begin
               lat  = cyc;
               data = iresp.data;
            end
            ireq.valid = 1'b0;
         end else if (lat >= 0) begin
            done = 1;
         end
         if (granted && beat < LW) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + 32'(beat);
            mem_resp_last  = (beat == LW - 1);
            if (beat == flush_beat) flush = 1'b1;
            beat++;
         end
         if (mem_req_valid === 1'b1) begin
            if (!granted && waitc < grant_wait) begin
               waitc++;
            end else begin
               mem_req_ready = 1'b1;
               if (!granted) raddr = mem_req_addr;
               granted = 1;
               nreq++;
            end
         end
      end
      ireq.valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      mem_resp_last = 1'b0; flush = 1'b0;
      $display("txn addr=%h data=%h latency=%0d mem_reqs=%0d req_addr=%h", a, data, lat, nreq, raddr);
   endtask

   task automatic test_reset();
      @(negedge clk);
      total_cnt++; if (iresp.addr_ok !== 1'b0) $display("FAIL reset_addr_ok: got %b expected 0", iresp.addr_ok); else passed_cnt++;
      total_cnt++; if (iresp.data_ok !== 1'b0) $display("FAIL reset_data_ok: got %b expected 0", iresp.data_ok); else passed_cnt++;
      total_cnt++; if (iresp.data !== 32'h0) $display("FAIL reset_data: got %h expected 0", iresp.data); else passed_cnt++;
      total_cnt++; if (mem_req_valid !== 1'b0) $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); else passed_cnt++;
      total_cnt++; if (mem_req_addr !== 64'h0) $display("FAIL reset_mem_req_addr: got %h expected 0", mem_req_addr); else passed_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_cold_miss();
      logic [31:0] d; int lat, nreq, okc, ferr; logic [63:0] ra;
      run_txn(64'h8000_0004, 32'h1000, 0, -1, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (d !== 32'h1001) $display("FAIL cold_miss_data: got %h expected %h", d, 32'h1001); else passed_cnt++;
      total_cnt++; if (lat !== 10) $display("FAIL cold_miss_latency: got %0d expected 10", lat); else passed_cnt++;
      total_cnt++; if (nreq !== 1) $display("FAIL cold_miss_reqs: got %0d expected 1", nreq); else passed_cnt++;
      total_cnt++; if (ra !== 64'h8000_0000) $display("FAIL cold_miss_req_addr: got %h expected %h", ra, 64'h8000_0000); else passed_cnt++;
      total_cnt++; if (mem_req_len !== 5'd7) $display("FAIL cold_miss_len: got %0d expected 7", mem_req_len); else passed_cnt++;
      total_cnt++; if (okc !== 1) $display("FAIL cold_miss_ok_cycles: got %0d expected 1", okc); else passed_cnt++;
      total_cnt++; if (ferr !== 0) $display("FAIL cold_miss_flag_pair: got %0d split cycles expected 0", ferr); else passed_cnt++;
   endtask

   task automatic test_hit();
      logic [31:0] d; int lat, nreq, okc, ferr; logic [63:0] ra;
      run_txn(64'h8000_001C, 32'hDEAD_0000, 0, -1, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (d !== 32'h1007) $display("FAIL hit_data: got %h expected %h", d, 32'h1007); else passed_cnt++;
      total_cnt++; if (lat !== 1) $display("FAIL hit_latency: got %0d expected 1", lat); else passed_cnt++;
      total_cnt++; if (nreq !== 0) $display("FAIL hit_reqs: got %0d expected 0", nreq); else passed_cnt++;
      total_cnt++; if (okc !== 1) $display("FAIL hit_ok_cycles: got %0d expected 1", okc); else passed_cnt++;
      run_txn(64'h8000_0000, 32'hDEAD_0000, 0, -1, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (d !== 32'h1000) $display("FAIL back_to_back_data: got %h expected %h", d, 32'h1000); else passed_cnt++;
      total_cnt++; if (lat !== 1) $display("FAIL back_to_back_latency: got %0d expected 1", lat); else passed_cnt++;
   endtask

   task automatic test_tag_mismatch();
      logic [31:0] d; int lat, nreq, okc, ferr; logic [63:0] ra;
      run_txn(64'h8000_0020, 32'h2000, 2, -1, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (d !== 32'h2000) $display("FAIL tag_miss_data: got %h expected %h", d, 32'h2000); else passed_cnt++;
      total_cnt++; if (lat !== 12) $display("FAIL tag_miss_latency: got %0d expected 12", lat); else passed_cnt++;
      total_cnt++; if (ra !== 64'h8000_0020) $display("FAIL tag_miss_req_addr: got %h expected %h", ra, 64'h8000_0020); else passed_cnt++;
      run_txn(64'h8000_0024, 32'hDEAD_0000, 0, -1, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (d !== 32'h2001 || nreq !== 0) $display("FAIL new_line_hit: got data %h reqs %0d expected %h reqs 0", d, nreq, 32'h2001); else passed_cnt++;
      run_txn(64'h8000_0004, 32'h1100, 0, -1, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (nreq !== 1) $display("FAIL old_line_remiss_reqs: got %0d expected 1", nreq); else passed_cnt++;
      total_cnt++; if (d !== 32'h1101) $display("FAIL old_line_remiss_data: got %h expected %h", d, 32'h1101); else passed_cnt++;
   endtask

   task automatic test_flush_refill();
      logic [31:0] d; int lat, nreq, okc, ferr; logic [63:0] ra;
      run_txn(64'h8000_0068, 32'h3000, 0, 3, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (d !== 32'h3002) $display("FAIL killed_refill_data: got %h expected %h", d, 32'h3002); else passed_cnt++;
      total_cnt++; if (lat !== 10) $display("FAIL killed_refill_latency: got %0d expected 10", lat); else passed_cnt++;
      run_txn(64'h8000_0068, 32'h3100, 0, -1, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (nreq !== 1) $display("FAIL killed_line_refills: got %0d reqs expected 1", nreq); else passed_cnt++;
      total_cnt++; if (d !== 32'h3102) $display("FAIL killed_line_refill_data: got %h expected %h", d, 32'h3102); else passed_cnt++;
      run_txn(64'h8000_0068, 32'hDEAD_0000, 0, -1, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (nreq !== 0 || lat !== 1) $display("FAIL refilled_line_hit: got reqs %0d latency %0d expected 0 and 1", nreq, lat); else passed_cnt++;
   endtask

   task automatic test_misaligned();
      logic [31:0] d; int lat, nreq, okc, ferr; logic [63:0] ra;
      run_txn(64'h8000_0002, 32'hDEAD_0000, 0, -1, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (d !== 32'h0) $display("FAIL misaligned_data: got %h expected 0", d); else passed_cnt++;
      total_cnt++; if (lat !== 1) $display("FAIL misaligned_latency: got %0d expected 1", lat); else passed_cnt++;
      total_cnt++; if (nreq !== 0) $display("FAIL misaligned_reqs: got %0d expected 0", nreq); else passed_cnt++;
      run_txn(64'h8000_006C, 32'hDEAD_0000, 0, -1, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (d !== 32'h3103 || nreq !== 0) $display("FAIL line_kept_after_misaligned: got data %h reqs %0d expected %h reqs 0", d, nreq, 32'h3103); else passed_cnt++;
   endtask

   task automatic test_flush_idle();
      logic [31:0] d; int lat, nreq, okc, ferr; logic [63:0] ra;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      run_txn(64'h8000_006C, 32'h3200, 0, -1, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (nreq !== 1 || d !== 32'h3203) $display("FAIL flush_idle_remiss: got reqs %0d data %h expected 1 and %h", nreq, d, 32'h3203); else passed_cnt++;
      run_txn(64'h8000_0060, 32'h3300, 0, -2, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (nreq !== 1 || d !== 32'h3300) $display("FAIL flush_at_accept_miss: got reqs %0d data %h expected 1 and %h", nreq, d, 32'h3300); else passed_cnt++;
   endtask

   task automatic test_reset_midburst();
      logic [31:0] d; int lat, nreq, okc, ferr; logic [63:0] ra;
      // Reset while the burst request is still pending.
      ireq.valid = 1'b1; ireq.addr = 64'h8000_0090;
      @(negedge clk);
      total_cnt++; if (mem_req_valid !== 1'b1) $display("FAIL mreq_before_reset: got %b expected 1", mem_req_valid); else passed_cnt++;
      #1 rst_n = 1'b0;
      #1;
      total_cnt++; if (mem_req_valid !== 1'b0) $display("FAIL mreq_async_drop: got %b expected 0", mem_req_valid); else passed_cnt++;
      ireq.valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // Reset during beat 5 of a refill.
      ireq.valid = 1'b1; ireq.addr = 64'h8000_0010;
      @(negedge clk);
      ireq.valid = 1'b0;
      mem_req_ready = 1'b1;
      for (int b = 0; b < 6; b++) begin
         @(negedge clk);
         mem_req_ready  = 1'b0;
         mem_resp_valid = 1'b1;
         mem_resp_data  = 32'h5000 + 32'(b);
         mem_resp_last  = 1'b0;
      end
      total_cnt++; if (mem_req_addr !== 64'h8000_0000) $display("FAIL midburst_req_addr: got %h expected %h", mem_req_addr, 64'h8000_0000); else passed_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++; if (iresp.addr_ok !== 1'b0 || iresp.data_ok !== 1'b0 || iresp.data !== 32'h0)
         $display("FAIL midburst_reset_resp: got ok %b%b data %h expected 00 and 0", iresp.addr_ok, iresp.data_ok, iresp.data); else passed_cnt++;
      total_cnt++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 64'h0)
         $display("FAIL midburst_reset_mem: got valid %b addr %h expected 0 and 0", mem_req_valid, mem_req_addr); else passed_cnt++;
      mem_resp_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_txn(64'h8000_0010, 32'h5100, 0, -1, d, lat, nreq, ra, okc, ferr);
      total_cnt++; if (nreq !== 1 || lat !== 10) $display("FAIL post_reset_refill: got reqs %0d latency %0d expected 1 and 10", nreq, lat); else passed_cnt++;
      total_cnt++; if (d !== 32'h5104) $display("FAIL post_reset_data: got %h expected %h", d, 32'h5104); else passed_cnt++;
   endtask

   initial begin
      total_cnt = 0; passed_cnt = 0;
      rst_n = 1'b0; flush = 1'b0;
      ireq = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_last = 1'b0;
      test_reset();
      test_cold_miss();
      test_hit();
      test_tag_mismatch();
      test_flush_refill();
      test_misaligned();
      test_flush_idle();
      test_reset_midburst();
      $display("%0d/%0d checks passed", passed_cnt, total_cnt);
      $finish;
   end

endmodule
